// File: rtl/bnn_layer_seq.sv
// bnn_layer_seq: binary neural-network layer with NEURONS XNOR-popcount neurons
// that all see the same input vector. The vector is streamed in BEATS beats of
// IN_W bits, and each beat carries its own weight slice for every neuron. Each
// neuron accumulates its popcount across the beats. The final sum is compared
// with a threshold that is sampled on the first beat of the vector. The result
// bits are held on a valid/ready output until the consumer accepts them.
//
// Optional feature: define BNN_POPCNT_OUT_EN to add the out_popcnt port, which
// exposes the per-neuron final accumulator values alongside out_bits.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous reset, active low
//   in_valid   - beat valid
//   in_ready   - layer can accept a beat (low while a result is held)
//   in_data    - activation bits, 1 = +1, 0 = -1
//   w_data     - weights, neuron n = w_data[n*IN_W +: IN_W]
//   thresh     - firing threshold, sampled on the first beat of a vector
//   out_valid  - result valid
//   out_ready  - consumer accepts result
//   out_bits   - bit n = 1 iff popcount_n >= threshold
//   out_popcnt - (BNN_POPCNT_OUT_EN only) final popcount per neuron
module bnn_layer_seq #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned NEURONS = 4,
  parameter int unsigned CNT_W   = $clog2(BEATS * IN_W + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [NEURONS*IN_W-1:0]    w_data,
  input  logic [CNT_W-1:0]           thresh,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef BNN_POPCNT_OUT_EN
  output logic [NEURONS*CNT_W-1:0]   out_popcnt,
`endif
  output logic [NEURONS-1:0]         out_bits
);

  localparam int unsigned BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAST = BEATS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [BC_W-1:0]                 beat_cnt_q, beat_cnt_d;
  logic [NEURONS-1:0][CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]                thr_q, thr_d;
  logic                            out_valid_q, out_valid_d;
  logic [NEURONS-1:0]              out_bits_q, out_bits_d;

  logic [NEURONS-1:0][CNT_W-1:0]   xp;
  logic [NEURONS-1:0][CNT_W-1:0]   sum;
  logic [CNT_W-1:0]                thr_eff;
  logic                            accept;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;

`ifdef BNN_POPCNT_OUT_EN
  // Accumulators already hold the final sums, unchanged, for the whole of HOLD.
  assign out_popcnt = acc_q;
`endif

  // Per-neuron XNOR popcount of the current beat.
  always_comb begin
    for (int unsigned n = 0; n < NEURONS; n++) begin
      xp[n] = CNT_W'($countones(~(in_data ^ w_data[n*IN_W +: IN_W])));
    end
  end

  // The first beat starts from zero and uses the live threshold, because
  // thr_q is only loaded on that same edge.
  always_comb begin
    thr_eff = (state_q == IDLE) ? thresh : thr_q;
    for (int unsigned n = 0; n < NEURONS; n++) begin
      sum[n] = ((state_q == IDLE) ? CNT_W'(0) : acc_q[n]) + xp[n];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (state_q == IDLE) begin
            thr_d = thresh;
          end
          acc_d = sum;
          if (beat_cnt_q == BC_W'(LAST)) begin
            for (int unsigned n = 0; n < NEURONS; n++) begin
              out_bits_d[n] = (sum[n] >= thr_eff);
            end
            out_valid_d = 1'b1;
            beat_cnt_d  = '0;
            state_d     = HOLD;
          end else begin
            beat_cnt_d = beat_cnt_q + BC_W'(1);
            state_d    = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
    end
  end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed testbench for bnn_layer_seq with default parameters
// (IN_W=8, BEATS=4, NEURONS=4, CNT_W=6).
module tb_bnn_layer_seq;

  localparam int unsigned IN_W    = 8;
  localparam int unsigned NEURONS = 4;
  localparam int unsigned CNT_W   = 6;

  // Mixed weight word: w3=FF, w2=00, w1=F0, w0=0F.
  localparam logic [31:0] W_MIX = 32'hFF00_F00F;
  localparam logic [31:0] W_ONE = 32'hFFFF_FFFF;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_W-1:0]           in_data;
  logic [NEURONS*IN_W-1:0]   w_data;
  logic [CNT_W-1:0]          thresh;
  logic                      out_valid;
  logic                      out_ready;
  logic [NEURONS-1:0]        out_bits;
`ifdef BNN_POPCNT_OUT_EN
  logic [NEURONS*CNT_W-1:0]  out_popcnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bnn_layer_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .w_data     (w_data),
    .thresh     (thresh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef BNN_POPCNT_OUT_EN
    .out_popcnt (out_popcnt),
`endif
    .out_bits   (out_bits)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Present one beat at a negedge, let it be accepted, and return at the next negedge.
  task automatic beat(input logic [7:0] d, input logic [31:0] w, input logic [5:0] t);
    in_valid = 1'b1;
    in_data  = d;
    w_data   = w;
    thresh   = t;
    check("in_ready_at_beat", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [7:0] d, input logic [31:0] w, input logic [5:0] t);
    for (int i = 0; i < 4; i++) begin
      beat(d, w, t);
      if (i < 3) check("valid_early", 32'(out_valid), 32'd0);
    end
    check("valid_latency", 32'(out_valid), 32'd1);
  endtask

  // Handshake the held result and check the release timing.
  task automatic take;
    out_ready = 1'b1;
    check("in_ready_hold", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic check_pc(input logic [5:0] p0, input logic [5:0] p1,
                          input logic [5:0] p2, input logic [5:0] p3);
`ifdef BNN_POPCNT_OUT_EN
    check("popcnt0", 32'(out_popcnt[0*CNT_W +: CNT_W]), 32'(p0));
    check("popcnt1", 32'(out_popcnt[1*CNT_W +: CNT_W]), 32'(p1));
    check("popcnt2", 32'(out_popcnt[2*CNT_W +: CNT_W]), 32'(p2));
    check("popcnt3", 32'(out_popcnt[3*CNT_W +: CNT_W]), 32'(p3));
`else
    if (p0 == p1 && p2 == p3 && p0 != p3) $display("note: mixed popcounts not exposed");
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    w_data    = '0;
    thresh    = '0;
    out_ready = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bits", 32'(out_bits), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);

    // All ones: every neuron reaches 32, threshold 32.
    run_vec(8'hFF, W_ONE, 6'd32);
    check("ones_bits", 32'(out_bits), 32'hF);
    check_pc(6'd32, 6'd32, 6'd32, 6'd32);
    take();

    // Mixed weights: 32,0,16,16 against threshold 16.
    run_vec(8'h0F, W_MIX, 6'd16);
    check("mixed_bits", 32'(out_bits), 32'hD);
    check_pc(6'd32, 6'd0, 6'd16, 6'd16);
    take();

    // Backpressure: beats offered during HOLD must be ignored.
    run_vec(8'h0F, W_MIX, 6'd16);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      w_data   = 32'h0;
      thresh   = 6'd0;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_bits", 32'(out_bits), 32'hD);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take();

    // Threshold above the maximum sum clears every bit; also confirms that the
    // beats ignored during HOLD left no residue.
    run_vec(8'hFF, W_ONE, 6'd33);
    check("thr_high_bits", 32'(out_bits), 32'h0);
    take();

    // Gap between beats 2 and 3, threshold changed to 0 after the first beat.
    beat(8'h0F, W_MIX, 6'd16);
    beat(8'h0F, W_MIX, 6'd0);
    repeat (3) begin
      @(negedge clk);
      check("gap_valid", 32'(out_valid), 32'd0);
    end
    beat(8'h0F, W_MIX, 6'd0);
    check("gap_valid3", 32'(out_valid), 32'd0);
    beat(8'h0F, W_MIX, 6'd0);
    check("gap_valid4", 32'(out_valid), 32'd1);
    check("gap_bits", 32'(out_bits), 32'hD);
    take();

    // A zero threshold fires every neuron even at popcount 0.
    run_vec(8'h00, W_ONE, 6'd0);
    check("thr_zero_bits", 32'(out_bits), 32'hF);
    check_pc(6'd0, 6'd0, 6'd0, 6'd0);
    take();

    // Reset after two beats discards the partial sums.
    beat(8'hFF, W_ONE, 6'd0);
    beat(8'hFF, W_ONE, 6'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    run_vec(8'h0F, W_MIX, 6'd16);
    check("midrst_bits", 32'(out_bits), 32'hD);
    check_pc(6'd32, 6'd0, 6'd16, 6'd16);
    take();

    // Reset while holding a result drops it.
    run_vec(8'hFF, W_ONE, 6'd32);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("holdrst_valid", 32'(out_valid), 32'd0);
    check("holdrst_bits", 32'(out_bits), 32'd0);
    check("holdrst_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
